// File: rtl/axis_frame_rr_arbiter.sv
// Round-robin AXI4-Stream frame arbiter. A grant is held from the first beat of a
// frame through its tlast beat, and the winner is forwarded through a registered output stage.
module axis_frame_rr_arbiter #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter bit USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int ID_WIDTH    = $clog2(S_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_axis_tvalid,
  output logic [S_COUNT-1:0]             s_axis_tready,
  input  logic [S_COUNT-1:0]             s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic                           busy,
  output logic [ID_WIDTH-1:0]            grant_index
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_index_q, last_grant_q;
  logic [ID_WIDTH-1:0]   sel_index, hi_index, lo_index;
  logic                  sel_found, hi_found, lo_found;
  logic                  out_ready, accept;

  logic [DATA_WIDTH-1:0] gnt_data;
  logic [KEEP_WIDTH-1:0] gnt_keep;
  logic [USER_WIDTH-1:0] gnt_user;
  logic                  gnt_valid, gnt_last;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic [USER_WIDTH-1:0] tuser_q;
  logic [ID_WIDTH-1:0]   tid_q;
  logic                  tvalid_q, tlast_q;

  // Ports above last_grant win over ports at or below it; lowest index wins within each group.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_index = '0;
    lo_index = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        if (i > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_index = ID_WIDTH'(i);
        end else begin
          lo_found = 1'b1;
          lo_index = ID_WIDTH'(i);
        end
      end
    end
    sel_found = hi_found | lo_found;
    sel_index = hi_found ? hi_index : lo_index;
  end

  always_comb begin
    gnt_data  = '0;
    gnt_keep  = '0;
    gnt_user  = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index_q == ID_WIDTH'(i)) begin
        gnt_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        gnt_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        gnt_valid = s_axis_tvalid[i];
        gnt_last  = s_axis_tlast[i];
      end
    end
  end

  assign out_ready = !tvalid_q || m_axis_tready;
  assign accept    = (state_q == ACTIVE) && out_ready && gnt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_index_q <= '0;
      last_grant_q  <= ID_WIDTH'(S_COUNT - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_found) begin
        grant_index_q <= sel_index;
        last_grant_q  <= sel_index;
      end
    end
  end

  // The grant survives source gaps; only an accepted tlast beat releases it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = ACTIVE;
      ACTIVE:  if (accept && gnt_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ACTIVE) begin
      for (int i = 0; i < S_COUNT; i++) begin
        if (grant_index_q == ID_WIDTH'(i)) s_axis_tready[i] = out_ready;
      end
    end
    busy        = (state_q == ACTIVE);
    grant_index = grant_index_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tid_q    <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (accept) begin
      tdata_q  <= gnt_data;
      tkeep_q  <= gnt_keep;
      tuser_q  <= gnt_user;
      tid_q    <= grant_index_q;
      tlast_q  <= gnt_last;
      tvalid_q <= 1'b1;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = KEEP_ENABLE ? tkeep_q : '1;
  assign m_axis_tuser  = USER_ENABLE ? tuser_q : '0;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Bench for axis_frame_rr_arbiter: cycle table, hand-written corner sequences and a
// randomized run checked against a frame-level round-robin model.
module tb_axis_frame_rr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [1:0] tid;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       mr;
    logic       busy;
    logic [1:0] gi;
    logic       mv;
    logic [1:0] tid;
    logic [3:0] rdy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tuser;
  logic [7:0]   m_tdata;
  logic [0:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [1:0]   m_tid;
  logic [0:0]   m_tuser;
  logic         busy;
  logic [1:0]   grant_index;

  logic [3:0]   fire;
  logic         ofire;
  logic [7:0]   snap_data;
  logic         snap_last, snap_user, snap_mvalid, snap_mready;
  logic [1:0]   snap_tid;
  logic [3:0]   snap_sready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_frame_rr_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tuser  (m_tuser),
    .busy          (busy),
    .grant_index   (grant_index)
  );

  // Drives controls at the falling edge, snapshots the handshakes, returns just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] l, input logic mr);
    @(negedge clk);
    rst      = r;
    s_tvalid = v;
    s_tlast  = l;
    m_tready = mr;
    #1;
    fire        = s_tvalid & s_tready;
    ofire       = m_tvalid & m_tready;
    snap_data   = m_tdata;
    snap_last   = m_tlast;
    snap_user   = m_tuser[0];
    snap_tid    = m_tid;
    snap_sready = s_tready;
    snap_mvalid = m_tvalid;
    snap_mready = m_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic runTable();
    vec_t tbl[14];
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0};
    tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'h1};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'h0};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 4'h2};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b1, 2'd1, 4'h0};
    tbl[7]  = '{1'b0, 4'h9, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0, 2'd1, 4'h8};
    tbl[8]  = '{1'b0, 4'h9, 4'hF, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3, 4'h0};
    tbl[9]  = '{1'b0, 4'h9, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 4'h0};
    tbl[10] = '{1'b0, 4'h9, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 4'h0};
    tbl[11] = '{1'b0, 4'h9, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'h0};
    tbl[12] = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0};
    tbl[13] = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0};
    s_tdata = 32'hA3A2A1A0;
    s_tuser = 4'hF;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].mr);
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      checkOutput($sformatf("tbl%0d_grant", i), 32'(grant_index), 32'(tbl[i].gi));
      checkOutput($sformatf("tbl%0d_mvalid", i), 32'(m_tvalid), 32'(tbl[i].mv));
      checkOutput($sformatf("tbl%0d_tid", i), 32'(m_tid), 32'(tbl[i].tid));
      checkOutput($sformatf("tbl%0d_sready", i), 32'(s_tready), 32'(tbl[i].rdy));
      if (tbl[i].mv) begin
        checkOutput($sformatf("tbl%0d_beat", i), 32'({m_tdata, m_tlast, m_tuser}),
                    32'({4'hA, 2'b00, tbl[i].tid, 1'b1, 1'b1}));
      end
    end
    checkOutput("tkeep_ones", 32'(m_tkeep), 32'(1));
  endtask

  task automatic runNoInterleave();
    logic [10:0] outs[8];
    logic [10:0] exp_b;
    logic [3:0]  v, l;
    int k = 0, c = 0, got = 0;
    logic p1done = 1'b0;
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
    while (got < 6 && c < 40) begin
      s_tdata[23:16] = 8'(8'h20 + k);
      s_tdata[15:8]  = 8'h5A;
      l = {1'b0, (k == 4), 1'b1, 1'b0};
      v = '0;
      v[2] = (k < 5);
      v[1] = (k < 5) ? c[0] : !p1done;
      applyStimulus(1'b0, v, l, 1'b1);
      if (k < 5) checkOutput("noint_ready1", 32'(snap_sready[1]), 32'(0));
      if (fire[2]) k++;
      if (fire[1]) p1done = 1'b1;
      if (ofire) begin
        outs[got] = {snap_tid, snap_data, snap_last};
        got++;
      end
      c++;
    end
    checkOutput("noint_count", 32'(got), 32'(6));
    for (int i = 0; i < 5; i++) begin
      exp_b = {2'd2, 8'(8'h20 + i), (i == 4)};
      checkOutput($sformatf("noint_beat%0d", i), 32'(outs[i]), 32'(exp_b));
    end
    checkOutput("noint_next", 32'(outs[5]), 32'({2'd1, 8'h5A, 1'b1}));
  endtask

  task automatic runBackpressure();
    logic [8:0] outs[16];
    logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] v, l;
    int k = 0, c = 0, got = 0;
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
    while (got < 8 && c < 80) begin
      s_tdata[15:8] = 8'(8'h10 + k);
      v = {2'b00, (k < 8), 1'b0};
      l = {2'b00, (k == 7), 1'b0};
      applyStimulus(1'b0, v, l, pat[c % 4]);
      if (snap_mvalid && !snap_mready) checkOutput("bp_ready_blocked", 32'(snap_sready), 32'(0));
      if (fire[1]) k++;
      if (ofire) begin
        if (got < 16) outs[got] = {snap_data, snap_last};
        got++;
      end
      c++;
    end
    checkOutput("bp_count", 32'(got), 32'(8));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("bp_beat%0d", i), 32'(outs[i]), 32'({8'(8'h10 + i), (i == 7)}));
    end
  endtask

  task automatic runMidReset();
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'h1, 4'h0, 1'b1);
    checkOutput("mrst_grant0", 32'({busy, grant_index}), 32'({1'b1, 2'd0}));
    for (int k = 0; k < 3; k++) begin
      s_tdata[7:0] = 8'(8'h40 + k);
      applyStimulus(1'b0, 4'h1, 4'h0, 1'b1);
    end
    checkOutput("mrst_beat2", 32'({m_tvalid, m_tdata, busy}), 32'({1'b1, 8'h42, 1'b1}));
    s_tdata[7:0] = 8'h43;
    applyStimulus(1'b1, 4'h3, 4'h0, 1'b1);
    checkOutput("mrst_dropped", 32'({m_tvalid, busy}), 32'(0));
    applyStimulus(1'b0, 4'h3, 4'h0, 1'b1);
    checkOutput("mrst_regrant", 32'({busy, grant_index}), 32'({1'b1, 2'd0}));
  endtask

  // Reference: every port keeps a first beat offered, so frames leave in strict rotation among ports with work left.
  task automatic runRandom();
    beat_t      src_q[N][$];
    int         flen[N][$];
    exp_t       exp_q[$];
    exp_t       e;
    beat_t      b;
    int         taken[N], base[N];
    int         remaining = 0, last = N - 1, cyc = 0, p, len;
    logic [3:0] v = '0, l = '0, first = '1;
    logic       ok;
    for (int q = 0; q < N; q++) begin
      taken[q] = 0;
      base[q]  = 0;
      for (int f = 0; f < int'($urandom_range(2, 4)); f++) begin
        len = $urandom_range(1, 5);
        flen[q].push_back(len);
        remaining++;
        for (int j = 0; j < len; j++) begin
          b.data = 8'($urandom);
          b.last = (j == len - 1);
          b.user = 1'($urandom);
          src_q[q].push_back(b);
        end
      end
    end
    while (remaining > 0) begin
      for (int off = 1; off <= N; off++) begin
        p = (last + off) % N;
        if (taken[p] < flen[p].size()) begin
          len = flen[p][taken[p]];
          for (int j = 0; j < len; j++) begin
            e.b   = src_q[p][base[p] + j];
            e.tid = 2'(p);
            exp_q.push_back(e);
          end
          base[p] += len;
          taken[p]++;
          remaining--;
          last = p;
          break;
        end
      end
    end
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
    while (cyc < 4000) begin
      for (int q = 0; q < N; q++) begin
        if (fire[q]) begin
          b = src_q[q].pop_front();
          first[q] = b.last;
        end
      end
      if (ofire && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rand_beat", 32'({snap_data, snap_last, snap_user, snap_tid}), 32'(e));
      end
      if (exp_q.size() == 0) break;
      for (int q = 0; q < N; q++) begin
        if (src_q[q].size() == 0) v[q] = 1'b0;
        else if (first[q]) v[q] = 1'b1;
        else if (!(v[q] && !fire[q])) v[q] = ($urandom_range(0, 9) >= 3);
        if (src_q[q].size() > 0) begin
          s_tdata[q*8 +: 8] = src_q[q][0].data;
          l[q]              = src_q[q][0].last;
          s_tuser[q]        = src_q[q][0].user;
        end
      end
      applyStimulus(1'b0, v, l, ($urandom_range(0, 9) < 7));
      ok = $onehot0(snap_sready) && !(snap_mvalid && !snap_mready && snap_sready != 4'h0);
      checkOutput("rand_ready_rule", 32'(ok), 32'(1));
      cyc++;
    end
    checkOutput("rand_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    rst      = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b0;
    runTable();
    runNoInterleave();
    runBackpressure();
    runMidReset();
    runRandom();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
